// File: rtl/upper_arb_ctrl.sv
// ---------------------------------------------------------------------------
// upper_arb_ctrl
// Two-requester round-robin arbiter feeding one shared lower->upper case
// converter and a single-entry output register with a valid/ready handshake.
// A counter tracks how many upper-cased bytes were delivered downstream.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0_valid/data/ready   requester 0 byte stream
//   req1_valid/data/ready   requester 1 byte stream
//   out_valid/data/src/     result register: converted byte, source index,
//   out_changed             and whether a letter was upper-cased
//   out_ready               downstream accept
//   clr_count               synchronous clear of conv_count
//   conv_count              saturating count of delivered upper-cased bytes
// ---------------------------------------------------------------------------
module upper_arb_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_src,
  output logic             out_changed,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] conv_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [7:0]       r_data;
  logic             r_src;
  logic             r_changed;
  logic             r_last;     // index of the most recently granted requester
  logic [CNT_W-1:0] r_count;

  logic       w_slot_free;
  logic       w_out_hs;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_accept;
  logic [7:0] w_sel_data;
  logic       w_is_lower;
  logic [7:0] w_conv_data;

  assign w_out_hs    = (r_state == ST_FULL) && out_ready;
  assign w_slot_free = (r_state == ST_EMPTY) || out_ready;

  // Under contention req0 wins only if req1 was granted last; w_gnt1 is the
  // complement whenever req1 is valid, so the grants are mutually exclusive.
  assign w_gnt0 = req0_valid && (!req1_valid || r_last);
  assign w_gnt1 = req1_valid && !w_gnt0;

  // rst_n gating keeps both readies low while reset is held even though the
  // empty register would otherwise report a free slot.
  assign w_rdy0   = w_gnt0 && w_slot_free && rst_n;
  assign w_rdy1   = w_gnt1 && w_slot_free && rst_n;
  assign w_accept = w_rdy0 || w_rdy1;

  // Single shared conversion path on the granted byte.
  assign w_sel_data  = w_gnt1 ? req1_data : req0_data;
  assign w_is_lower  = (w_sel_data >= 8'h61) && (w_sel_data <= 8'h7A);
  assign w_conv_data = w_sel_data & ~{2'b00, w_is_lower, 5'b00000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_data    <= 8'h00;
      r_src     <= 1'b0;
      r_changed <= 1'b0;
      r_last    <= 1'b1;
      r_count   <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state   <= ST_FULL;
            r_data    <= w_conv_data;
            r_src     <= w_gnt1;
            r_changed <= w_is_lower;
            r_last    <= w_gnt1;
          end
        end
        ST_FULL: begin
          // A new accept implies out_ready here, so reload without a bubble.
          if (w_accept) begin
            r_data    <= w_conv_data;
            r_src     <= w_gnt1;
            r_changed <= w_is_lower;
            r_last    <= w_gnt1;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase

      if (clr_count) begin
        r_count <= '0;
      end else if (w_out_hs && r_changed && (r_count != CNT_MAX)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign req0_ready  = w_rdy0;
  assign req1_ready  = w_rdy1;
  assign out_valid   = (r_state == ST_FULL);
  assign out_data    = r_data;
  assign out_src     = r_src;
  assign out_changed = r_changed;
  assign conv_count  = r_count;

endmodule

// File: tb/tb_upper_arb_ctrl.sv
module tb_upper_arb_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid;
  logic [7:0]       req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_data;
  logic             req1_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_src;
  logic             out_changed;
  logic             out_ready;
  logic             clr_count;
  logic [CNT_W-1:0] conv_count;

  int tests = 0;
  int fails = 0;

  upper_arb_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_src     (out_src),
    .out_changed (out_changed),
    .out_ready   (out_ready),
    .clr_count   (clr_count),
    .conv_count  (conv_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bnd_in  [4];
  logic [7:0] bnd_out [4];
  logic       bnd_chg [4];

  initial begin
    bnd_in[0] = 8'h60; bnd_out[0] = 8'h60; bnd_chg[0] = 1'b0;
    bnd_in[1] = 8'h7A; bnd_out[1] = 8'h5A; bnd_chg[1] = 1'b1;
    bnd_in[2] = 8'h7B; bnd_out[2] = 8'h7B; bnd_chg[2] = 1'b0;
    bnd_in[3] = 8'h7F; bnd_out[3] = 8'h7F; bnd_chg[3] = 1'b0;

    rst_n = 1'b1; req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00; out_ready = 1'b0; clr_count = 1'b0;
    #1 rst_n = 1'b0;
    req0_valid = 1'b1;
    #2;
    // Reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_out_changed", 32'(out_changed), 0);
    chk("rst_count", 32'(conv_count), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    req0_valid = 1'b0;

    // Single byte right after reset release
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h61; out_ready = 1'b1;
    #1;
    chk("single_ready0", 32'(req0_ready), 1);
    chk("single_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 'h41);
    chk("single_src", 32'(out_src), 0);
    chk("single_changed", 32'(out_changed), 1);
    tick();
    chk("single_drained", 32'(out_valid), 0);
    chk("single_count", 32'(conv_count), 1);
    $display("[TB] single byte 0x61 -> 0x41 count=%0d", conv_count);

    // Boundary bytes from req1, streamed back-to-back
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1; req1_data = bnd_in[i];
      tick();
      chk("bnd_valid", 32'(out_valid), 1);
      chk("bnd_data", 32'(out_data), 32'(bnd_out[i]));
      chk("bnd_changed", 32'(out_changed), 32'(bnd_chg[i]));
      chk("bnd_src", 32'(out_src), 1);
      $display("[TB] boundary in=%02h out=%02h changed=%0b", bnd_in[i], out_data, out_changed);
    end
    req1_valid = 1'b0;
    tick();
    chk("bnd_drained", 32'(out_valid), 0);
    chk("bnd_count", 32'(conv_count), 2);

    // Contention: idle cycle above must not move the pointer (req1 was last)
    req0_valid = 1'b1; req0_data = 8'h62;
    req1_valid = 1'b1; req1_data = 8'h31;
    for (int i = 0; i < 4; i++) begin
      #0;
      chk("cont_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      chk("cont_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      tick();
      chk("cont_valid", 32'(out_valid), 1);
      chk("cont_src", 32'(out_src), 32'(i % 2));
      chk("cont_data", 32'(out_data), (i % 2 == 0) ? 'h42 : 'h31);
      $display("[TB] contention beat %0d src=%0d data=%02h", i, out_src, out_data);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("cont_drained", 32'(out_valid), 0);
    chk("cont_count", 32'(conv_count), 4);

    // Backpressure
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h63;
    tick();
    req0_data = 8'h65;
    req1_valid = 1'b1; req1_data = 8'h64;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready0", 32'(req0_ready), 0);
      chk("bp_ready1", 32'(req1_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 'h43);
      chk("bp_src", 32'(out_src), 0);
      $display("[TB] backpressure cycle %0d data=%02h", i, out_data);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready1", 32'(req1_ready), 1);
    tick();
    chk("bp_next_data", 32'(out_data), 'h44);
    chk("bp_next_src", 32'(out_src), 1);
    tick();
    chk("bp_follow_data", 32'(out_data), 'h45);
    chk("bp_follow_src", 32'(out_src), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 0);
    chk("bp_count", 32'(conv_count), 7);

    // Saturation: 20 more letters on a 4-bit counter
    req0_valid = 1'b1; req0_data = 8'h61;
    for (int i = 0; i < 20; i++) tick();
    req0_valid = 1'b0;
    tick();
    chk("sat_count", 32'(conv_count), 15);
    $display("[TB] saturation count=%0d", conv_count);

    // Clear on the same cycle as a letter handshake
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0; clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("clr_count", 32'(conv_count), 0);
    chk("clr_drained", 32'(out_valid), 0);
    $display("[TB] clear with handshake count=%0d", conv_count);

    // Reset while FULL
    req0_valid = 1'b1; req0_data = 8'h61;
    tick();
    tick();
    req0_valid = 1'b0; out_ready = 1'b0;
    chk("prerst_valid", 32'(out_valid), 1);
    chk("prerst_count", 32'(conv_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(conv_count), 0);
    chk("midrst_data", 32'(out_data), 0);
    req0_valid = 1'b1; req1_valid = 1'b1; req1_data = 8'h62;
    #0;
    chk("midrst_ready0", 32'(req0_ready), 0);
    chk("midrst_ready1", 32'(req1_ready), 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("postrst_ready0", 32'(req0_ready), 1);
    chk("postrst_ready1", 32'(req1_ready), 0);
    tick();
    chk("postrst_valid", 32'(out_valid), 1);
    chk("postrst_src", 32'(out_src), 0);
    $display("[TB] after reset first grant src=%0d", out_src);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/upper_arb_ctrl.md
UPPER_ARB_CTRL -- requirements
Module: upper_arb_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the converted-letter counter (legal range 4..32).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low; the only reset in the block.
REQ-004 Port: req0_valid  input  1  requester 0 offers a byte.
REQ-005 Port: req0_data  input  8  requester 0 byte.
REQ-006 Port: req0_ready  output  1  requester 0 byte accepted this cycle when high together with req0_valid.
REQ-007 Port: req1_valid  input  1  requester 1 offers a byte.
REQ-008 Port: req1_data  input  8  requester 1 byte.
REQ-009 Port: req1_ready  output  1  requester 1 byte accepted this cycle when high together with req1_valid.
REQ-010 Port: out_valid  output  1  out_data/out_src/out_changed hold a valid result.
REQ-011 Port: out_data  output  8  converted byte.
REQ-012 Port: out_src  output  1  index of the requester that supplied out_data.
REQ-013 Port: out_changed  output  1  high when out_data differs from the input byte (a letter was upper-cased).
REQ-014 Port: out_ready  input  1  consumer accepts the result when high together with out_valid.
REQ-015 Port: clr_count  input  1  synchronous clear of conv_count.
REQ-016 Port: conv_count  output  CNT_W  number of upper-cased bytes delivered since reset or the last clear.

Function
REQ-017 The block SHALL contain exactly one shared case-conversion datapath: bytes 0x61..0x7A SHALL have bit 5 cleared; every other byte value, including 0x60 and 0x7B..0xFF, SHALL pass unchanged.
REQ-018 The output stage SHALL be a single register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 "Slot free" SHALL be defined as EMPTY, or FULL with out_ready=1 in the same cycle.
REQ-020 Arbitration SHALL be combinational each cycle:
  - one requester valid: grant that requester;
  - both valid: grant the requester not granted most recently (round-robin).
REQ-021 reqN_ready SHALL equal grant_N AND slot free; the two ready signals SHALL never both be high in one cycle.
REQ-022 On an accept, the next rising edge SHALL load the converted byte, the source index and the changed flag, set out_valid=1 and update the last-grant pointer. Latency from accept to out_valid is 1 cycle.
REQ-023 An out handshake with no simultaneous accept SHALL clear out_valid on the next edge.
REQ-024 An out handshake with a simultaneous accept SHALL reload the register with no bubble (sustained throughput of 1 byte/cycle).
REQ-025 While FULL and out_ready=0, out_data, out_src and out_changed SHALL stay stable, and both ready signals SHALL be 0.
REQ-026 A requester SHALL not be granted when its valid is low; an idle cycle SHALL not change the last-grant pointer.
REQ-027 conv_count SHALL increment by 1 on each out handshake with out_changed=1, saturating at 2^CNT_W-1 with no wrap-around.
REQ-028 clr_count SHALL set conv_count to 0 on the next edge and SHALL take priority over a simultaneous increment.

Reset
REQ-029 When rst_n=0, asynchronously: out_valid=0, out_data=0x00, out_src=0, out_changed=0, conv_count=0, and last-grant pointer=1, so req0 wins the first contention.
REQ-030 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL discard any held result without delivering it.
REQ-032 After rst_n deasserts, the block SHALL accept a request on the first rising edge.

Verification
REQ-033 Single byte: req0 sends 0x61 with out_ready=1 -> one cycle later out_valid=1, out_data=0x41, out_src=0, out_changed=1; conv_count=1 after the handshake.
REQ-034 Boundaries: req1 sends 0x60, 0x7A, 0x7B, 0x7F in turn -> outputs are 0x60, 0x5A, 0x7B, 0x7F with out_changed 0,1,0,0 respectively.
REQ-035 Contention: both requesters hold valid continuously with out_ready=1 -> grants alternate 0,1,0,1 at one byte per cycle, with no bubbles.
REQ-036 Backpressure: out_ready=0 for 5 cycles while FULL -> outputs hold stable and both ready signals stay 0; after out_ready=1 the held byte is delivered and the next byte follows in the next cycle.
REQ-037 Counter with CNT_W=4: deliver 20 letters -> conv_count holds at 15; assert clr_count on the same cycle as a letter handshake -> conv_count=0.
REQ-038 Reset while FULL: rst_n pulsed low mid-cycle -> out_valid and conv_count go to 0 immediately, without waiting for an edge; after release, with both requesters valid, the first grant goes to req0.
